distribute_1xn_simple_seq: RTL

- Parametrised, registered successor to the 1x2 combinational distribute switch.
- Routes one input word to any subset of N output ports (unicast or multicast), selected by an N-bit destination mask.
- Each output port has its own FIFO, so outputs drain independently under valid/ready backpressure.
- Sits at the root or internal nodes of distribution trees feeding PE arrays.

---
 rtl/distribute_1xn_simple_seq_if.sv | 32 +++
 rtl/distribute_1xn_simple_seq.sv | 110 +++++++++++
 2 files changed

// File: rtl/distribute_1xn_simple_seq_if.sv
// +-----------------------------------------------------------------------------+
// | distribute_1xn_simple_seq_if : handshake/data bundle for the 1xN distributor |
// | Revision 1.0                                                                 |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface distribute_1xn_simple_seq_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_OUTPUT    = 4,
  parameter int COMMAND_WIDTH = NUM_OUTPUT
);
  logic                             i_valid;
  logic [DATA_WIDTH-1:0]            i_data_bus;
  logic                             o_ready;
  logic                             i_en;
  logic [COMMAND_WIDTH-1:0]         i_cmd;
  logic [NUM_OUTPUT-1:0]            o_valid;
  logic [NUM_OUTPUT*DATA_WIDTH-1:0] o_data_bus;
  logic [NUM_OUTPUT-1:0]            i_ready;

  modport slave (
    input  i_valid, i_data_bus, i_en, i_cmd, i_ready,
    output o_ready, o_valid, o_data_bus
  );

  modport master (
    output i_valid, i_data_bus, i_en, i_cmd, i_ready,
    input  o_ready, o_valid, o_data_bus
  );
endinterface

`default_nettype wire

// File: rtl/distribute_1xn_simple_seq.sv
// +-----------------------------------------------------------------------------+
// | distribute_1xn_simple_seq : registered 1xN unicast/multicast distributor     |
// | with one FIFO per output port. Revision 1.0                                  |
// +-----------------------------------------------------------------------------+
`default_nettype none

module distribute_1xn_simple_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_OUTPUT    = 4,
  parameter int COMMAND_WIDTH = NUM_OUTPUT,
  parameter int FIFO_DEPTH    = 2
) (
  input  wire                             clk,
  input  wire                             rst,
  distribute_1xn_simple_seq_if.slave      bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  generate
    if (COMMAND_WIDTH != NUM_OUTPUT) begin : g_bad_cmd_width
      $error("COMMAND_WIDTH must equal NUM_OUTPUT");
    end
    if (NUM_OUTPUT < 2) begin : g_bad_num_output
      $error("NUM_OUTPUT must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  logic [CNT_W-1:0]      count [NUM_OUTPUT];
  logic [DATA_WIDTH-1:0] head  [NUM_OUTPUT];
  logic [NUM_OUTPUT-1:0] full;
  logic [NUM_OUTPUT-1:0] empty;
  logic [NUM_OUTPUT-1:0] push;
  logic [NUM_OUTPUT-1:0] pop;
  logic                  ready;
  logic                  accept;
  logic [NUM_OUTPUT*DATA_WIDTH-1:0] data_out;

  always_comb begin
    full  = '0;
    empty = '0;
    for (int k = 0; k < NUM_OUTPUT; k++) begin
      full[k]  = (count[k] == CNT_W'(FIFO_DEPTH));
      empty[k] = (count[k] == '0);
    end
  end

  // Space is judged on current occupancy only; a same-cycle pop never frees a slot.
  assign ready  = bus.i_en & ~rst & ~(|(bus.i_cmd & full));
  assign accept = bus.i_valid & ready;
  assign push   = {NUM_OUTPUT{accept}} & bus.i_cmd;
  assign pop    = ~empty & bus.i_ready;

  generate
    for (genvar k = 0; k < NUM_OUTPUT; k++) begin : g_fifo
      logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0]      wr_ptr;
      logic [PTR_W-1:0]      rd_ptr;
      logic [CNT_W-1:0]      occ;

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          occ    <= '0;
        end else begin
          if (push[k]) begin
            wr_ptr <= wr_ptr + 1'b1;
          end
          if (pop[k]) begin
            rd_ptr <= rd_ptr + 1'b1;
          end
          case ({push[k], pop[k]})
            2'b10:   occ <= occ + CNT_W'(1);
            2'b01:   occ <= occ - CNT_W'(1);
            default: occ <= occ;
          endcase
        end
      end

      // Storage needs no reset: it is only observed through a non-empty head.
      always_ff @(posedge clk) begin
        if (!rst && push[k]) begin
          mem[wr_ptr] <= bus.i_data_bus;
        end
      end

      assign count[k] = occ;
      assign head[k]  = mem[rd_ptr];
    end
  endgenerate

  always_comb begin
    data_out = '0;
    for (int k = 0; k < NUM_OUTPUT; k++) begin
      data_out[k*DATA_WIDTH +: DATA_WIDTH] = empty[k] ? '0 : head[k];
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_valid    = ~empty;
  assign bus.o_data_bus = data_out;

endmodule

`default_nettype wire
